// File: rtl/rx_clock_recovery.sv
// Oversampled RX clock/data recovery: edge-realigned phase counter, mid-bit sampler, lock detect.
// Strobe lags the sample-phase cycle by one clock; no backpressure. Optional 3-sample vote: RX_MAJORITY_VOTE_EN.
module rx_clock_recovery #(
  parameter int OSR        = 8,
  parameter int BITS       = $clog2(OSR),
  parameter int LOCK_EDGES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            serial_in,
  output logic [BITS-1:0] count,
  output logic            rx_clock,
  output logic            bit_strobe,
  output logic            bit_out,
  output logic            locked
);

  localparam int HALF = OSR / 2;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int SAMPLE_PHASE = HALF + 1;
`else
  localparam int SAMPLE_PHASE = HALF;
`endif
  localparam logic [BITS-1:0] SAMPLE_CNT = BITS'(SAMPLE_PHASE);
  localparam logic [BITS-1:0] HALF_CNT   = BITS'(HALF);
  localparam logic [BITS-1:0] LAST_CNT   = BITS'(OSR - 1);
  localparam logic [BITS-1:0] ONE_CNT    = BITS'(1);
  localparam logic [3:0]      LOCK_CNT   = 4'(LOCK_EDGES);

  logic       s1, s2, s3;
  logic       edge_det;
  logic       in_window;
  logic       sample_now;
  logic       wrap;
  logic       sample_bit;
  logic [3:0] good_cnt;
  logic [3:0] good_next;
  logic [3:0] idle_cnt;

  assign edge_det   = s2 ^ s3;
  assign in_window  = (count == LAST_CNT) || (count == '0) || (count == ONE_CNT);
  assign sample_now = enable && !edge_det && (count == SAMPLE_CNT);
  assign wrap       = enable && !edge_det && (count == LAST_CNT);
  assign good_next  = (good_cnt == LOCK_CNT) ? good_cnt : good_cnt + 4'd1;
  assign rx_clock   = (count < HALF_CNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= serial_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // An edge marks phase 0, so the following cycle is phase 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      if (edge_det) count <= ONE_CNT;
      else          count <= count + ONE_CNT;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic vote_a, vote_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vote_a <= 1'b0;
      vote_b <= 1'b0;
    end else if (enable) begin
      if (edge_det) begin
        vote_a <= 1'b0;
        vote_b <= 1'b0;
      end else begin
        if (count == BITS'(HALF - 1)) vote_a <= s2;
        if (count == HALF_CNT)        vote_b <= s2;
      end
    end
  end

  assign sample_bit = (vote_a & vote_b) | (vote_a & s2) | (vote_b & s2);
`else
  assign sample_bit = s2;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_strobe <= 1'b0;
      bit_out    <= 1'b0;
    end else begin
      bit_strobe <= sample_now;
      if (sample_now) bit_out <= sample_bit;
    end
  end

  // Idle counter saturates at 15; the 16th edge-free wrap drops lock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      good_cnt <= 4'd0;
      idle_cnt <= 4'd0;
      locked   <= 1'b0;
    end else if (enable) begin
      if (edge_det) begin
        idle_cnt <= 4'd0;
        if (in_window) begin
          good_cnt <= good_next;
          if (good_next == LOCK_CNT) locked <= 1'b1;
        end else begin
          good_cnt <= 4'd0;
          locked   <= 1'b0;
        end
      end else if (wrap) begin
        if (idle_cnt == 4'hF) begin
          good_cnt <= 4'd0;
          locked   <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 4'd1;
        end
      end
    end
  end

endmodule
